// File: rtl/mem_uart_pkg.sv
// ============================================================================
// Module : mem_uart_pkg
// Brief  : Shared types and constants for the BRAM <-> UART block movers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ_REQ  = 3'd1,
        S_READ_WAIT = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_ACK  = 3'd4,
        S_WAIT_TX   = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_SHIFT     = 2;

endpackage

`default_nettype wire

// File: rtl/mem_to_uart_varcount.sv
// ============================================================================
// Module : VarCount
// Brief  : Width-parameterised up-counter with synchronous clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module VarCount #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear takes priority so a restart never sees a stale increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/mem_to_uart.sv
// ============================================================================
// Module : mem_to_uart
// Brief  : Streams WORD_COUNT BRAM words to a UART TX, LSB byte first.
//          Optional CHECKSUM_EN appends an XOR byte after the data stream.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_to_uart
    import mem_uart_pkg::*;
#(
    parameter int WORD_COUNT   = 30,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        START,
    input  logic        TX_BUSY,
    output logic        TX_START,
    output logic [7:0]  TX_DATA,
    output logic [31:0] addrB,
    output logic        enB,
    output logic [3:0]  weB,
    input  logic [31:0] dataFromB,
    output logic        DONE_READING
);

    localparam logic [29:0] c_LAST_IDX  = (WORD_COUNT > 0) ? 30'(WORD_COUNT - 1) : 30'd0;
    localparam logic [1:0]  c_LAT_LAST  = 2'(READ_LATENCY - 1);
    localparam logic [1:0]  c_LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t      r_state;
    logic [1:0]  r_byte_pos;
    logic [31:0] r_word;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_en;
    logic        r_done;

    logic [29:0] w_word_idx;
    logic [1:0]  w_lat_cnt;
    logic        w_idx_clr;
    logic        w_idx_inc;
    logic        w_lat_clr;
    logic        w_lat_inc;
    logic        w_lat_done;
    logic        w_more_words;
    logic        w_cks_phase;
    logic [4:0]  w_sel;
    logic [7:0]  w_data_byte;
    logic [7:0]  w_tx_byte;

`ifdef CHECKSUM_EN
    logic        r_cks_phase;
    logic [7:0]  r_xor;
    assign w_cks_phase = r_cks_phase;
    assign w_tx_byte   = r_cks_phase ? r_xor : w_data_byte;
`else
    assign w_cks_phase = 1'b0;
    assign w_tx_byte   = w_data_byte;
`endif

    assign w_sel        = {r_byte_pos, 3'b000};
    assign w_data_byte  = r_word[w_sel +: 8];
    assign w_more_words = (WORD_COUNT > 1) && (w_word_idx < c_LAST_IDX);
    assign w_lat_done   = (r_state == S_READ_WAIT) && (w_lat_cnt == c_LAT_LAST);

    assign w_idx_clr = (r_state == S_IDLE) && START;
    assign w_idx_inc = (r_state == S_WAIT_TX) && !TX_BUSY && !w_cks_phase
                       && (r_byte_pos == c_LAST_BYTE) && w_more_words;
    assign w_lat_clr = (r_state == S_READ_REQ);
    assign w_lat_inc = (r_state == S_READ_WAIT);

    VarCount #(.WIDTH(30)) u_word_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_clr   (w_idx_clr),
        .i_inc   (w_idx_inc),
        .o_count (w_word_idx)
    );

    VarCount #(.WIDTH(2)) u_lat_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_clr   (w_lat_clr),
        .i_inc   (w_lat_inc),
        .o_count (w_lat_cnt)
    );

    // enB is raised on the edge that enters READ_REQ so it is high during that state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_byte_pos <= 2'd0;
            r_word     <= 32'd0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
`ifdef CHECKSUM_EN
            r_cks_phase <= 1'b0;
            r_xor       <= 8'h00;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_byte_pos <= 2'd0;
`ifdef CHECKSUM_EN
                        r_xor       <= 8'h00;
                        r_cks_phase <= (WORD_COUNT == 0);
`endif
                        if (WORD_COUNT == 0) begin
`ifdef CHECKSUM_EN
                            r_state <= S_SEND;
`else
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_state <= S_READ_REQ;
                            r_en    <= 1'b1;
                        end
                    end
                end
                S_READ_REQ: begin
                    r_state <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (w_lat_done) begin
                        r_word  <= dataFromB;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!TX_BUSY) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_tx_byte;
`ifdef CHECKSUM_EN
                        if (!r_cks_phase) begin
                            r_xor <= r_xor ^ w_tx_byte;
                        end
`endif
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    r_state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (!TX_BUSY) begin
                        r_byte_pos <= r_byte_pos + 2'd1;
                        if (w_cks_phase) begin
                            r_state <= S_DONE;
                        end else if (r_byte_pos != c_LAST_BYTE) begin
                            r_state <= S_SEND;
                        end else if (w_more_words) begin
                            r_state <= S_READ_REQ;
                            r_en    <= 1'b1;
                        end else begin
`ifdef CHECKSUM_EN
                            r_cks_phase <= 1'b1;
                            r_state     <= S_SEND;
`else
                            r_state <= S_DONE;
`endif
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign TX_START     = r_tx_start;
    assign TX_DATA      = r_tx_data;
    assign enB          = r_en;
    assign addrB        = 32'(w_word_idx) << ADDR_SHIFT;
    assign weB          = 4'h0;
    assign DONE_READING = r_done;

endmodule

`default_nettype wire
